// File: rtl/exc_redirect_ctrl.sv
// exc_redirect_ctrl: sequences exception/ERET pipeline flush, CP0 update and fetch redirect
module exc_redirect_ctrl #(
  parameter logic [31:0] EXC_ENTRY = 32'hBFC0_0380,
  parameter logic [3:0]  DRAIN_MAX = 4'd15
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        exc_valid,
  input  logic [4:0]  exc_code,
  input  logic [31:0] exc_pc,
  input  logic [31:0] exc_badvaddr,
  input  logic        exc_in_delay_slot,
  input  logic        eret_valid,
  input  logic [31:0] epc_in,
  input  logic        ibus_busy,
  input  logic        dbus_busy,
  output logic        flush,
  output logic        busy,
  output logic        cp0_exc_we,
  output logic [4:0]  cp0_code,
  output logic [31:0] cp0_epc,
  output logic        cp0_bd,
  output logic        cp0_badvaddr_we,
  output logic [31:0] cp0_badvaddr,
  output logic        cp0_exl_clr,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc
);
  typedef enum logic [1:0] {IDLE, DRAIN, COMMIT, REDIRECT} state_t;
  state_t      state, state_nx;
  logic [3:0]  cnt;
  logic        kind_eret;
  logic [31:0] tgt;
  logic        accept, drain_done;
  assign accept     = (state == IDLE) && (exc_valid || eret_valid);
  assign drain_done = (!ibus_busy && !dbus_busy) || (cnt == DRAIN_MAX - 4'd1);
  // State register; reset aborts any sequence in flight
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nx;
  end
  // Next state and state-decoded pulse outputs
  always_comb begin
    state_nx        = state == IDLE   ? (accept ? DRAIN : IDLE) :
                      state == DRAIN  ? (drain_done ? COMMIT : DRAIN) :
                      state == COMMIT ? REDIRECT : IDLE;
    busy            = state != IDLE;
    flush           = state != IDLE;
    cp0_exc_we      = state == COMMIT && !kind_eret;
    cp0_exl_clr     = state == COMMIT && kind_eret;
    cp0_badvaddr_we = state == COMMIT && !kind_eret && (cp0_code == 5'd4 || cp0_code == 5'd5);
    redirect_valid  = state == REDIRECT;
  end
  // Request latches, drain watchdog counter and redirect target
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt          <= '0;
      kind_eret    <= 1'b0;
      tgt          <= '0;
      cp0_code     <= '0;
      cp0_epc      <= '0;
      cp0_bd       <= 1'b0;
      cp0_badvaddr <= '0;
      redirect_pc  <= '0;
    end else begin
      cnt <= state == DRAIN ? cnt + 4'd1 : '0;
      if (accept) begin
        kind_eret <= !exc_valid;
        tgt       <= exc_valid ? EXC_ENTRY : epc_in;
        if (exc_valid) begin
          cp0_code     <= exc_code;
          cp0_epc      <= exc_pc;
          cp0_bd       <= exc_in_delay_slot;
          cp0_badvaddr <= exc_badvaddr;
        end
      end
      if (state == COMMIT) redirect_pc <= tgt;
    end
  end
endmodule

// File: tb/tb_exc_redirect_ctrl.sv
// tb_exc_redirect_ctrl: randomized transaction-level check of exc_redirect_ctrl
module tb_exc_redirect_ctrl;
  localparam logic [31:0] ENTRY = 32'hBFC0_0380;
  localparam int DMAX = 15;
  logic clk = 0, resetn = 0;
  logic exc_valid = 0, exc_in_delay_slot = 0, eret_valid = 0, ibus_busy = 0, dbus_busy = 0;
  logic [4:0] exc_code = 0;
  logic [31:0] exc_pc = 0, exc_badvaddr = 0, epc_in = 0;
  logic flush, busy, cp0_exc_we, cp0_bd, cp0_badvaddr_we, cp0_exl_clr, redirect_valid;
  logic [4:0] cp0_code;
  logic [31:0] cp0_epc, cp0_badvaddr, redirect_pc;
  int checks = 0, errors = 0;
  logic [4:0] m_code = 0;
  logic [31:0] m_pc = 0, m_bad = 0, m_rpc = 0;
  logic m_bd = 0;
  always #5 clk = ~clk;
  exc_redirect_ctrl dut (
    .clk(clk), .resetn(resetn), .exc_valid(exc_valid), .exc_code(exc_code), .exc_pc(exc_pc),
    .exc_badvaddr(exc_badvaddr), .exc_in_delay_slot(exc_in_delay_slot), .eret_valid(eret_valid),
    .epc_in(epc_in), .ibus_busy(ibus_busy), .dbus_busy(dbus_busy), .flush(flush), .busy(busy),
    .cp0_exc_we(cp0_exc_we), .cp0_code(cp0_code), .cp0_epc(cp0_epc), .cp0_bd(cp0_bd),
    .cp0_badvaddr_we(cp0_badvaddr_we), .cp0_badvaddr(cp0_badvaddr), .cp0_exl_clr(cp0_exl_clr),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic check_cycle(input string tag, input bit f, input bit exw, input bit exl, input bit bvw, input bit rv);
    check({tag, " flush"}, flush, f);
    check({tag, " busy"}, busy, f);
    check({tag, " cp0_exc_we"}, cp0_exc_we, exw);
    check({tag, " cp0_exl_clr"}, cp0_exl_clr, exl);
    check({tag, " cp0_badvaddr_we"}, cp0_badvaddr_we, bvw);
    check({tag, " redirect_valid"}, redirect_valid, rv);
    check({tag, " cp0_code"}, cp0_code, m_code);
    check({tag, " cp0_epc"}, cp0_epc, m_pc);
    check({tag, " cp0_bd"}, cp0_bd, m_bd);
    check({tag, " cp0_badvaddr"}, cp0_badvaddr, m_bad);
    check({tag, " redirect_pc"}, redirect_pc, m_rpc);
  endtask
  // One request with the busy bus(es) held for b DRAIN cycles; optional junk requests while active
  task automatic txn(input string tag, input bit ev, input bit rv, input logic [4:0] code,
                     input logic [31:0] pc, input logic [31:0] bad, input bit bd, input logic [31:0] epc,
                     input int b, input logic [1:0] sel, input bit inj);
    int l;
    bit is_exc, adr;
    logic [31:0] tgt;
    l = (b + 1 < DMAX) ? b + 1 : DMAX;
    is_exc = ev;
    adr = ev && (code == 5'd4 || code == 5'd5);
    tgt = ev ? ENTRY : epc;
    exc_valid = ev; eret_valid = rv; exc_code = code; exc_pc = pc;
    exc_badvaddr = bad; exc_in_delay_slot = bd; epc_in = epc;
    @(posedge clk); #1;
    if (ev) begin m_code = code; m_pc = pc; m_bad = bad; m_bd = bd; end
    for (int c = 1; c <= l + 3; c++) begin
      if (c > 1) begin @(posedge clk); #1; end
      if (c == l + 2) m_rpc = tgt;
      check_cycle($sformatf("%s c%0d", tag, c), c <= l + 2, c == l + 1 && is_exc,
                  c == l + 1 && !is_exc, c == l + 1 && adr, c == l + 2);
      exc_valid = inj && c <= l + 2 && $urandom_range(1) == 1;
      eret_valid = inj && c <= l + 2 && $urandom_range(1) == 1;
      exc_code = 5'($urandom); exc_pc = $urandom; exc_badvaddr = $urandom;
      exc_in_delay_slot = 1'($urandom); epc_in = $urandom;
      ibus_busy = c <= b && sel[0];
      dbus_busy = c <= b && sel[1];
    end
    exc_valid = 0; eret_valid = 0; ibus_busy = 0; dbus_busy = 0;
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #1;
    check_cycle("reset", 0, 0, 0, 0, 0);
    @(negedge clk) resetn = 1;
    @(posedge clk); #1;
    txn("ov", 1, 0, 5'd12, 32'h8000_0100, 32'h0, 0, 32'h0, 0, 2'b11, 0);
    txn("adel", 1, 0, 5'd4, 32'h8000_0200, 32'h1234_5673, 1, 32'h0, 0, 2'b11, 0);
    txn("eret", 0, 1, 5'd0, 32'h0, 32'h0, 0, 32'h8000_2000, 0, 2'b11, 0);
    txn("dbus5", 1, 0, 5'd5, 32'h8000_0300, 32'hDEAD_BEEF, 0, 32'h0, 5, 2'b10, 0);
    txn("stuck", 0, 1, 5'd0, 32'h0, 32'h0, 0, 32'h8000_4000, 1000, 2'b10, 0);
    txn("wd14", 1, 0, 5'd8, 32'h8000_0400, 32'h0, 1, 32'h0, 14, 2'b01, 0);
    txn("both", 1, 1, 5'd10, 32'h8000_0500, 32'h0, 0, 32'h8000_6000, 3, 2'b11, 1);
    for (int i = 0; i < 40; i++) begin
      bit ev, rv;
      ev = 1'($urandom); rv = !ev || 1'($urandom);
      txn($sformatf("rnd%0d", i), ev, rv, 5'($urandom_range(3, 6)), $urandom, $urandom,
          1'($urandom), $urandom, $urandom_range(0, 18), 2'($urandom_range(1, 3)), 1'($urandom));
    end
    exc_valid = 1; exc_code = 5'd5; exc_pc = 32'h8000_0600; exc_badvaddr = 32'h0BAD_0000;
    @(posedge clk); #1;
    exc_valid = 0;
    @(posedge clk); #1;
    check("rst pre cp0_exc_we", cp0_exc_we, 1);
    resetn = 0;
    exc_valid = 1; eret_valid = 1;
    #1;
    m_code = 0; m_pc = 0; m_bad = 0; m_bd = 0; m_rpc = 0;
    check_cycle("rst mid", 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    exc_valid = 0; eret_valid = 0;
    @(negedge clk) resetn = 1;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      check_cycle($sformatf("rst post c%0d", c), 0, 0, 0, 0, 0);
    end
    txn("after", 1, 0, 5'd4, 32'h8000_0700, 32'h0000_0011, 1, 32'h0, 2, 2'b01, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
